puf_uart_crp_ctrl: RTL and testbench

Parametrised challenge-response controller that sits between the UART core and an arbiter-PUF array. It assembles a CHAL_BYTES-byte challenge from received UART bytes and drives it to the PUF with a start/done handshake. It then serialises the RESP_BITS-bit response back as bytes through the UART transmit handshake. It replaces the hard-wired single-byte/single-bit loop at the top level with configurable widths, inter-byte timeout, PUF timeout and error reporting.

---
 rtl/puf_uart_crp_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_puf_uart_crp_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_uart_crp_ctrl.sv
// puf_uart_crp_ctrl: assembles a UART challenge, runs the PUF handshake
// and returns the response byte-serially, with timeouts and error count.
module puf_uart_crp_ctrl #(
  parameter int         CHAL_BYTES   = 8,
  parameter int         RESP_BITS    = 8,
  parameter int         BYTE_TIMEOUT = 500000,
  parameter int         PUF_TIMEOUT  = 4096,
  parameter logic [7:0] ERR_BYTE     = 8'hEE
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_byte,
  input  logic                    rx_error,
  output logic                    tx_start,
  output logic [7:0]              tx_byte,
  input  logic                    tx_busy,
  output logic [8*CHAL_BYTES-1:0] chal,
  output logic                    puf_start,
  input  logic                    puf_done,
  input  logic [RESP_BITS-1:0]    puf_resp,
  output logic                    busy,
  output logic [7:0]              last_resp,
  output logic [7:0]              err_cnt
);

  localparam int RB = (RESP_BITS + 7) / 8;
  localparam int RW = 8 * RB;
  localparam int IW = $clog2(CHAL_BYTES + 1);
  localparam int OW = $clog2(RB + 1);
  localparam int BW = $clog2(BYTE_TIMEOUT + 1);
  localparam int PW = $clog2(PUF_TIMEOUT + 1);

  localparam logic [IW-1:0] I_LAST = IW'(CHAL_BYTES - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BYTE_TIMEOUT - 1);
  localparam logic [PW-1:0] P_LAST = PW'(PUF_TIMEOUT);
  localparam logic [OW-1:0] O_FULL = OW'(RB);
  localparam logic [OW-1:0] O_ONE  = OW'(1);

  typedef enum logic [2:0] {
    S_RX,
    S_EVAL,
    S_TX_REQ,
    S_TX_HI,
    S_TX_LO
  } state_t;

  state_t state_q, state_d;

  logic [IW-1:0] idx_q;
  logic [BW-1:0] btmr_q;
  logic [PW-1:0] ptmr_q;
  logic [OW-1:0] oidx_q;
  logic [OW-1:0] ocnt_q;
  logic [RW-1:0] resp_q;
  logic [RW-1:0] resp_pad;

  logic rx_take;
  logic rx_abort;
  logic byte_to;
  logic frame_done;
  logic puf_ok;
  logic puf_to;
  logic tx_go;
  logic err_inc;

  assign resp_pad = RW'(puf_resp);
  assign busy     = (state_q != S_RX);
  assign err_inc  = rx_abort | byte_to | puf_to;

  always_comb begin
    state_d    = state_q;
    rx_take    = 1'b0;
    rx_abort   = 1'b0;
    byte_to    = 1'b0;
    frame_done = 1'b0;
    puf_ok     = 1'b0;
    puf_to     = 1'b0;
    tx_go      = 1'b0;
    unique case (state_q)
      S_RX: begin
        // an error strobe always wins over a coincident byte
        if (rx_error) begin
          rx_abort = (idx_q != '0);
        end else if (rx_valid) begin
          rx_take = 1'b1;
          if (idx_q == I_LAST) begin
            frame_done = 1'b1;
            state_d    = S_EVAL;
          end
        end else if (idx_q != '0 && btmr_q == B_LAST) begin
          byte_to = 1'b1;
        end
      end
      S_EVAL: begin
        if (puf_done) begin
          puf_ok  = 1'b1;
          state_d = S_TX_REQ;
        end else if (ptmr_q == P_LAST) begin
          puf_to  = 1'b1;
          state_d = S_TX_REQ;
        end
      end
      S_TX_REQ: begin
        if (!tx_busy) begin
          tx_go   = 1'b1;
          state_d = S_TX_HI;
        end
      end
      S_TX_HI: begin
        if (tx_busy) state_d = S_TX_LO;
      end
      S_TX_LO: begin
        if (!tx_busy) begin
          state_d = (oidx_q == ocnt_q) ? S_RX : S_TX_REQ;
        end
      end
      default: state_d = S_RX;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RX;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      btmr_q <= '0;
      chal   <= '0;
    end else begin
      if (rx_take) chal[{idx_q, 3'b000} +: 8] <= rx_byte;
      if (frame_done || rx_abort || byte_to) idx_q <= '0;
      else if (rx_take)                      idx_q <= idx_q + 1'b1;
      // idle-gap timer only runs inside a partial frame
      if (rx_take || rx_abort || byte_to || idx_q == '0) btmr_q <= '0;
      else                                               btmr_q <= btmr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptmr_q    <= '0;
      puf_start <= 1'b0;
    end else begin
      puf_start <= frame_done;
      if (state_q == S_EVAL) ptmr_q <= ptmr_q + 1'b1;
      else                   ptmr_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_q    <= '0;
      oidx_q    <= '0;
      ocnt_q    <= '0;
      last_resp <= '0;
      tx_byte   <= '0;
      tx_start  <= 1'b0;
    end else begin
      tx_start <= tx_go;
      if (puf_ok) begin
        resp_q    <= resp_pad;
        last_resp <= resp_pad[7:0];
        oidx_q    <= '0;
        ocnt_q    <= O_FULL;
      end else if (puf_to) begin
        resp_q <= RW'(ERR_BYTE);
        oidx_q <= '0;
        ocnt_q <= O_ONE;
      end else if (tx_go) begin
        tx_byte <= resp_q[{oidx_q, 3'b000} +: 8];
        oidx_q  <= oidx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_inc && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_puf_uart_crp_ctrl.sv
// tb_puf_uart_crp_ctrl: directed bench with a transaction-level model
// for a 12-bit and an 8-bit response controller driven side by side.
module tb_puf_uart_crp_ctrl;

  localparam int BT = 40;
  localparam int PT = 30;

  logic        clk;
  logic        rst_n;
  logic        rx_valid;
  logic        rx_error;
  logic [7:0]  rx_byte;
  logic        tx_busy;
  logic        puf_done;
  logic [11:0] puf_resp;

  logic        a_txs, a_ps, a_busy;
  logic [7:0]  a_txb, a_last, a_err;
  logic [63:0] a_chal;
  logic        b_txs, b_ps, b_busy;
  logic [7:0]  b_txb, b_last, b_err;
  logic [63:0] b_chal;

  int n_chk  = 0;
  int n_pass = 0;

  bit cmp_en   = 0;
  bit exp_ps   = 0;
  bit m_busy   = 0;
  bit uart_act = 0;

  logic [63:0] m_chal = '0;
  int          m_idx  = 0;
  logic [7:0]  m_err  = '0;
  logic [7:0]  m_last = '0;
  logic [7:0]  exp_a[$];
  logic [7:0]  exp_b[$];

  logic [7:0] a_hold = '0;
  logic [7:0] a_hist[16];
  int a_tx_n = 0;
  int b_tx_n = 0;
  int ps_n   = 0;

  puf_uart_crp_ctrl #(
    .CHAL_BYTES(8), .RESP_BITS(12), .BYTE_TIMEOUT(BT),
    .PUF_TIMEOUT(PT), .ERR_BYTE(8'hEE)
  ) u_a (
    .clk(clk), .rst_n(rst_n),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_error(rx_error),
    .tx_start(a_txs), .tx_byte(a_txb), .tx_busy(tx_busy),
    .chal(a_chal), .puf_start(a_ps), .puf_done(puf_done),
    .puf_resp(puf_resp), .busy(a_busy),
    .last_resp(a_last), .err_cnt(a_err)
  );

  puf_uart_crp_ctrl #(
    .CHAL_BYTES(8), .RESP_BITS(8), .BYTE_TIMEOUT(BT),
    .PUF_TIMEOUT(PT), .ERR_BYTE(8'hEE)
  ) u_b (
    .clk(clk), .rst_n(rst_n),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_error(rx_error),
    .tx_start(b_txs), .tx_byte(b_txb), .tx_busy(tx_busy),
    .chal(b_chal), .puf_start(b_ps), .puf_done(puf_done),
    .puf_resp(puf_resp[7:0]), .busy(b_busy),
    .last_resp(b_last), .err_cnt(b_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // UART stand-in: busy rises 2 cycles after a start, lasts 6 cycles
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      if ((a_txs || b_txs) && rst_n) begin
        uart_act = 1;
        repeat (2) @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat (6) @(posedge clk);
        #1 tx_busy = 1'b0;
        uart_act = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic [8:0] e;
    if (cmp_en) begin
      chk("chal_a", a_chal, m_chal);
      chk("chal_b", b_chal, m_chal);
      chk("err_a", a_err, m_err);
      chk("err_b", b_err, m_err);
      chk("last_a", a_last, m_last);
      chk("last_b", b_last, m_last);
      chk("pstart_a", a_ps, exp_ps);
      chk("pstart_b", b_ps, exp_ps);
      if (uart_act && !a_txs) chk("hold_a", a_txb, a_hold);
    end
    exp_ps = 0;
    if (a_ps) ps_n++;
    if (a_txs) begin
      chk("tx_gap_a", uart_act, 0);
      e = (exp_a.size() != 0) ? {1'b0, exp_a.pop_front()} : 9'h100;
      chk("tx_byte_a", {1'b0, a_txb}, e);
      a_hold = a_txb;
      if (a_tx_n < 16) a_hist[a_tx_n] = a_txb;
      a_tx_n++;
    end
    if (b_txs) begin
      chk("tx_gap_b", uart_act, 0);
      e = (exp_b.size() != 0) ? {1'b0, exp_b.pop_front()} : 9'h100;
      chk("tx_byte_b", {1'b0, b_txb}, e);
      b_tx_n++;
    end
  end

  task automatic send(input logic [7:0] b, input logic err);
    @(posedge clk);
    #1 rx_valid = 1'b1; rx_byte = b; rx_error = err;
    @(posedge clk);
    if (!m_busy) begin
      if (err) begin
        if (m_idx != 0) begin
          m_idx = 0;
          if (m_err != 8'hFF) m_err = m_err + 1;
        end
      end else begin
        m_chal[8*m_idx +: 8] = b;
        m_idx++;
        if (m_idx == 8) begin
          m_idx  = 0;
          m_busy = 1;
          exp_ps = 1;
        end
      end
    end
    #1 rx_valid = 1'b0; rx_error = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] base);
    for (int i = 0; i < 8; i++) send(base + 8'(i), 1'b0);
  endtask

  task automatic respond(input logic [11:0] r);
    @(posedge clk);
    #1 puf_done = 1'b1; puf_resp = r;
    @(posedge clk);
    exp_a.push_back(r[7:0]);
    exp_a.push_back({4'h0, r[11:8]});
    exp_b.push_back(r[7:0]);
    m_last = r[7:0];
    #1 puf_done = 1'b0;
    @(negedge clk);
    chk("lat_tx_early", a_txs, 0);
    @(negedge clk);
    chk("lat_tx_2cyc", a_txs, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((a_busy || b_busy || uart_act) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_a", a_busy, 0);
    chk("idle_b", b_busy, 0);
    chk("txq_a", exp_a.size(), 0);
    chk("txq_b", exp_b.size(), 0);
    m_busy = 0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; rx_valid = 1'b0; rx_error = 1'b0; rx_byte = '0;
    puf_done = 1'b0; puf_resp = '0;
    repeat (2) @(negedge clk);
    chk("rst0_chal", a_chal, 0);
    chk("rst0_err", a_err, 0);
    chk("rst0_last", a_last, 0);
    chk("rst0_busy", a_busy, 0);
    chk("rst0_txs", a_txs, 0);
    chk("rst0_txb", a_txb, 0);
    chk("rst0_ps", a_ps, 0);
    rst_n = 1'b1;
    cmp_en = 1;

    // basic frame, a stray byte during EVAL, 8- and 12-bit replies
    send_frame(8'h01);
    @(negedge clk);
    chk("chal_lit", a_chal, 64'h0807060504030201);
    send(8'h77, 1'b0);
    respond(12'h0A5);
    wait_idle();
    chk("last_lit_b", b_last, 8'hA5);
    chk("ps_lit1", ps_n, 1);

    send_frame(8'hB1);
    respond(12'hABC);
    wait_idle();
    chk("hist0", a_hist[0], 8'hA5);
    chk("hist1", a_hist[1], 8'h00);
    chk("hist2", a_hist[2], 8'hBC);
    chk("hist3", a_hist[3], 8'h0A);
    chk("last_lit_a", a_last, 8'hBC);

    // inter-byte timeout discards a 3-byte partial frame
    send(8'hD1, 1'b0); send(8'hD2, 1'b0); send(8'hD3, 1'b0);
    repeat (BT - 3) @(posedge clk);
    cmp_en = 0;
    repeat (6) @(posedge clk);
    m_idx = 0;
    m_err = m_err + 1;
    @(negedge clk);
    cmp_en = 1;
    chk("bto_err", a_err, 1);
    chk("bto_ps", ps_n, 2);
    send_frame(8'hC1);
    respond(12'h15A);
    wait_idle();

    // framing errors: mid-frame abort, coincident byte, idle error
    send(8'h41, 1'b0); send(8'h42, 1'b0);
    send(8'h43, 1'b0); send(8'h44, 1'b0);
    send(8'h45, 1'b1);
    chk("rxe_err", a_err, 2);
    send(8'h51, 1'b0); send(8'h52, 1'b0);
    send(8'h99, 1'b1);
    @(negedge clk);
    chk("drop_byte", a_chal[23:16], 8'h43);
    chk("rxe_err2", a_err, 3);
    send(8'h00, 1'b1);
    @(negedge clk);
    chk("rxe_idle", a_err, 3);
    send_frame(8'h21);
    respond(12'h5E1);
    wait_idle();

    // PUF never answers: one ERR_BYTE goes out
    send_frame(8'h61);
    repeat (PT - 5) @(posedge clk);
    cmp_en = 0;
    exp_a.push_back(8'hEE);
    exp_b.push_back(8'hEE);
    m_err = m_err + 1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    cmp_en = 1;
    wait_idle();
    chk("pto_err", a_err, 4);
    chk("pto_last", a_last, 8'hE1);

    // async reset while waiting for the UART to finish
    send_frame(8'h31);
    respond(12'h3C7);
    n = 0;
    while (!tx_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("uart_busy_seen", tx_busy, 1);
    @(negedge clk);
    #2 cmp_en = 0; rst_n = 1'b0;
    #1;
    chk("rst_chal", a_chal, 0);
    chk("rst_err", a_err, 0);
    chk("rst_last", a_last, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_txs", a_txs, 0);
    chk("rst_txb", a_txb, 0);
    chk("rst_ps", a_ps, 0);
    chk("rst_err_b", b_err, 0);
    chk("rst_busy_b", b_busy, 0);
    m_chal = '0; m_idx = 0; m_err = '0; m_last = '0;
    m_busy = 0; exp_ps = 0;
    exp_a.delete();
    exp_b.delete();
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (uart_act && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    cmp_en = 1;
    send_frame(8'h10);
    @(negedge clk);
    chk("post_rst_chal", a_chal, 64'h1716151413121110);
    respond(12'h0F0);
    wait_idle();

    chk("tx_total_a", a_tx_n, 12);
    chk("tx_total_b", b_tx_n, 7);
    chk("ps_total", ps_n, 7);
    chk("final_err", a_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
